// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU pipeline.
// Fetch stage uses the PC step, reset PC and the buffered fetch entry type.
package cpu_pkg;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [PC_W-1:0] PC_STEP          = 32'd2;
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0100;

   // Instruction word fields: IR[31] addressing mode, IR[30:27] opcode
   localparam int unsigned IR_MODE_BIT = 31;
   localparam int unsigned IR_OPC_MSB  = 30;
   localparam int unsigned IR_OPC_LSB  = 27;
   localparam int unsigned OPC_W       = IR_OPC_MSB - IR_OPC_LSB + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } fetch_entry_t;

   function automatic logic [OPC_W-1:0] ir_opcode(input logic [INSTR_W-1:0] ir);
      return ir[IR_OPC_MSB:IR_OPC_LSB];
   endfunction

   function automatic logic ir_mode(input logic [INSTR_W-1:0] ir);
      return ir[IR_MODE_BIT];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head entry is read straight from storage.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type entry_t = cpu_pkg::fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  entry_t                       push_data,
   input  logic                         pop,
   output entry_t                       head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   // Flush wins over any push/pop presented on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues RAM reads under grant and buffer credit,
// and hands {instr, pc} entries to execute over valid/ready.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_gnt,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_cs,
   output logic                  mem_oe,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [31:0]           instr_pc,
   input  logic                  instr_ready,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  halt
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int unsigned CRD_W = CNT_W + 1;

   logic [PC_W-1:0]  fetch_pc;
   logic [PC_W-1:0]  tag_pc;
   logic             outstanding;
   logic             drop;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             pop_c;
   logic             push_c;
   logic             issue_c;
   logic [CRD_W-1:0] credit_used_c;

   assign mem_we = 1'b0;

   assign pop_c  = instr_valid && instr_ready;
   assign push_c = outstanding && !drop && !redirect_valid;

   // Entries held or in flight after this edge's pop must leave room for one more
   assign credit_used_c = CRD_W'(count) + CRD_W'(outstanding) - CRD_W'(pop_c);
   assign issue_c = mem_gnt && !halt && !redirect_valid &&
                    (credit_used_c < CRD_W'(FIFO_DEPTH));

   always_comb begin
      push_entry       = '0;
      push_entry.instr = INSTR_W'(mem_rdata);
      push_entry.pc    = tag_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         tag_pc      <= '0;
         outstanding <= 1'b0;
         drop        <= 1'b0;
         mem_addr    <= '0;
         mem_cs      <= 1'b0;
         mem_oe      <= 1'b0;
      end else begin
         drop        <= redirect_valid && outstanding;
         outstanding <= issue_c;
         mem_cs      <= issue_c;
         mem_oe      <= issue_c;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
         end else if (issue_c) begin
            fetch_pc <= fetch_pc + PC_STEP;
         end
         if (issue_c) begin
            mem_addr <= fetch_pc[ADDR_WIDTH-1:0];
            tag_pc   <= fetch_pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push_c),
      .push_data (push_entry),
      .pop       (pop_c),
      .head      (head),
      .count     (count)
   );

   assign instr_valid = (count != '0);
   assign instr       = DATA_WIDTH'(head.instr);
   assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// scored against a transaction-level model of issue/delivery order.
module tb_instr_fetch_unit;

   localparam int unsigned AW    = 28;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_gnt = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_cs, mem_oe, mem_we;
   logic [DW-1:0] mem_rdata;
   logic          instr_valid;
   logic [DW-1:0] instr;
   logic [31:0]   instr_pc;
   logic          instr_ready = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [31:0]   redirect_pc = '0;
   logic          halt = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RESET_PC   (32'h100),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_gnt        (mem_gnt),
      .mem_addr       (mem_addr),
      .mem_cs         (mem_cs),
      .mem_oe         (mem_oe),
      .mem_we         (mem_we),
      .mem_rdata      (mem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt)
   );

   // RAM contents: program words at a few addresses, an address-derived pattern elsewhere
   function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
      case (a)
         28'h100: return 32'h1000011E;
         28'h102: return 32'h00000120;
         28'h104: return 32'h1800011C;
         28'h11A: return 32'h7800000A;
         default: return {4'hC, a};
      endcase
   endfunction

   assign mem_rdata = ram_word(mem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_gnt = 1'b1; instr_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
      tick(); tick();
      tests++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL reset_mem_cs got %0h want 0", mem_cs); end
      tests++; if (mem_oe !== 1'b0) begin fails++; $display("FAIL reset_mem_oe got %0h want 0", mem_oe); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %0h want 0", mem_we); end
      tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h want 0", instr_valid); end
      tests++; if (instr !== '0) begin fails++; $display("FAIL reset_instr got %0h want 0", instr); end
      tests++; if (instr_pc !== '0) begin fails++; $display("FAIL reset_instr_pc got %0h want 0", instr_pc); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pc_e;
      mem_gnt = 1'b1; instr_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i < 3) begin
            pc_e = 32'h100 + 32'(2 * i);
            tests++; if (mem_cs !== 1'b1 || mem_addr !== pc_e[AW-1:0]) begin
               fails++; $display("FAIL b2b_issue%0d got cs=%0h addr=%0h want cs=1 addr=%0h", i, mem_cs, mem_addr, pc_e[AW-1:0]);
            end
         end
         if (i > 0) begin
            pc_e = 32'h100 + 32'(2 * (i - 1));
            tests++; if (instr_valid !== 1'b1 || instr_pc !== pc_e || instr !== ram_word(pc_e[AW-1:0])) begin
               fails++; $display("FAIL b2b_out%0d got v=%0h instr=%0h pc=%0h want v=1 instr=%0h pc=%0h",
                                 i - 1, instr_valid, instr, instr_pc, ram_word(pc_e[AW-1:0]), pc_e);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      mem_gnt = 1'b1; instr_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      do_reset();
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'h100) begin fails++; $display("FAIL bp_issue0 got cs=%0h addr=%0h want cs=1 addr=100", mem_cs, mem_addr); end
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'h102) begin fails++; $display("FAIL bp_issue1 got cs=%0h addr=%0h want cs=1 addr=102", mem_cs, mem_addr); end
      tick();
      tests++; if (mem_cs !== 1'b0) begin fails++; $display("FAIL bp_full_cs got %0h want 0", mem_cs); end
      tick();
      tests++; if (mem_cs !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
         fails++; $display("FAIL bp_hold got cs=%0h v=%0h pc=%0h want cs=0 v=1 pc=100", mem_cs, instr_valid, instr_pc);
      end
      instr_ready = 1'b1;
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'h104 || instr_pc !== 32'h102 || instr !== 32'h00000120) begin
         fails++; $display("FAIL bp_drain0 got cs=%0h addr=%0h pc=%0h instr=%0h want cs=1 addr=104 pc=102 instr=120",
                           mem_cs, mem_addr, instr_pc, instr);
      end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || instr !== 32'h1800011C) begin
         fails++; $display("FAIL bp_drain1 got v=%0h pc=%0h instr=%0h want v=1 pc=104 instr=1800011c", instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_redirect();
      mem_gnt = 1'b1; instr_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
      do_reset();
      tick();
      tick();
      tests++; if (mem_addr !== 28'h102 || mem_cs !== 1'b1) begin fails++; $display("FAIL redir_pre got cs=%0h addr=%0h want cs=1 addr=102", mem_cs, mem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h11A;
      tick();
      redirect_valid = 1'b0;
      tests++; if (mem_cs !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL redir_flush got cs=%0h v=%0h want cs=0 v=0", mem_cs, instr_valid); end
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'h11A || instr_valid !== 1'b0) begin
         fails++; $display("FAIL redir_issue got cs=%0h addr=%0h v=%0h want cs=1 addr=11a v=0", mem_cs, mem_addr, instr_valid);
      end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr !== 32'h7800000A || instr_pc !== 32'h11A) begin
         fails++; $display("FAIL redir_out got v=%0h instr=%0h pc=%0h want v=1 instr=7800000a pc=11a", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_gaps();
      mem_gnt = 1'b1; instr_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      do_reset();
      tick();
      mem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (mem_cs !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            fails++; $display("FAIL gnt_gap%0d got cs=%0h v=%0h pc=%0h want cs=0 v=1 pc=100", i, mem_cs, instr_valid, instr_pc);
         end
      end
      mem_gnt = 1'b1; halt = 1'b1; instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (mem_cs !== 1'b0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL halt_gap%0d got cs=%0h v=%0h want cs=0 v=0", i, mem_cs, instr_valid);
         end
      end
      halt = 1'b0;
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'h102) begin fails++; $display("FAIL gap_resume got cs=%0h addr=%0h want cs=1 addr=102", mem_cs, mem_addr); end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h102 || instr !== 32'h00000120) begin
         fails++; $display("FAIL gap_out got v=%0h pc=%0h instr=%0h want v=1 pc=102 instr=120", instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_async_reset();
      mem_gnt = 1'b1; instr_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0;
      do_reset();
      tick(); tick();
      tests++; if (mem_cs !== 1'b1 || instr_valid !== 1'b1) begin fails++; $display("FAIL arst_pre got cs=%0h v=%0h want cs=1 v=1", mem_cs, instr_valid); end
      #2 rst = 1'b1;
      #1;
      tests++; if (mem_cs !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL arst_async got cs=%0h v=%0h want cs=0 v=0", mem_cs, instr_valid); end
      tick();
      rst = 1'b0;
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'h100) begin fails++; $display("FAIL arst_restart got cs=%0h addr=%0h want cs=1 addr=100", mem_cs, mem_addr); end
   endtask

   task automatic test_pc_wrap();
      mem_gnt = 1'b1; instr_ready = 1'b1; halt = 1'b0;
      do_reset();
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      tick();
      tests++; if (mem_cs !== 1'b1 || mem_addr !== 28'hFFFFFFE) begin fails++; $display("FAIL wrap_addr0 got cs=%0h addr=%0h want cs=1 addr=ffffffe", mem_cs, mem_addr); end
      tick();
      tests++; if (mem_addr !== 28'h0 || instr_pc !== 32'hFFFF_FFFE || instr !== 32'hCFFFFFFE) begin
         fails++; $display("FAIL wrap_step1 got addr=%0h pc=%0h instr=%0h want addr=0 pc=fffffffe instr=cffffffe", mem_addr, instr_pc, instr);
      end
      tick();
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hC0000000) begin
         fails++; $display("FAIL wrap_step2 got v=%0h pc=%0h instr=%0h want v=1 pc=0 instr=c0000000", instr_valid, instr_pc, instr);
      end
   endtask

   // Model: items are issued and delivered in PC order from the last redirect target;
   // pending counts issued-not-delivered items, inflight marks one issued last edge.
   task automatic test_random();
      logic [31:0] exp_issue_pc;
      logic [31:0] exp_deliver_pc;
      int          pending;
      bit          inflight;
      bit          exp_valid, pop, can_issue;
      mem_gnt = 1'b0; instr_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      do_reset();
      exp_issue_pc = 32'h100; exp_deliver_pc = 32'h100; pending = 0; inflight = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         mem_gnt        = ($urandom_range(0, 3) != 0);
         instr_ready    = ($urandom_range(0, 2) != 0);
         halt           = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 29) == 0);
         redirect_pc    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 'hFFF)) : $urandom();
         exp_valid = (pending - int'(inflight)) > 0;
         tests++; if (instr_valid !== exp_valid) begin
            fails++; $display("FAIL rnd_valid cyc%0d got %0h want %0h", cyc, instr_valid, exp_valid);
         end
         if (exp_valid) begin
            tests++; if (instr_pc !== exp_deliver_pc || instr !== ram_word(exp_deliver_pc[AW-1:0])) begin
               fails++; $display("FAIL rnd_head cyc%0d got pc=%0h instr=%0h want pc=%0h instr=%0h",
                                 cyc, instr_pc, instr, exp_deliver_pc, ram_word(exp_deliver_pc[AW-1:0]));
            end
         end
         pop       = exp_valid && instr_ready && !redirect_valid;
         can_issue = mem_gnt && !halt && !redirect_valid && ((pending - int'(pop)) < int'(DEPTH));
         if (redirect_valid) begin
            pending = 0; exp_issue_pc = redirect_pc; exp_deliver_pc = redirect_pc;
         end else if (pop) begin
            pending--; exp_deliver_pc = exp_deliver_pc + 32'd2;
         end
         if (can_issue) pending++;
         inflight = can_issue;
         tick();
         tests++; if (mem_cs !== can_issue || mem_oe !== can_issue || mem_we !== 1'b0) begin
            fails++; $display("FAIL rnd_cs cyc%0d got cs=%0h oe=%0h we=%0h want cs=oe=%0h we=0", cyc, mem_cs, mem_oe, mem_we, can_issue);
         end
         if (can_issue) begin
            tests++; if (mem_addr !== exp_issue_pc[AW-1:0]) begin
               fails++; $display("FAIL rnd_addr cyc%0d got %0h want %0h", cyc, mem_addr, exp_issue_pc[AW-1:0]);
            end
            exp_issue_pc = exp_issue_pc + 32'd2;
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_redirect();
      test_gaps();
      test_async_reset();
      test_pc_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Synthesizable fetch stage of the accumulator CPU.
- Owns the program counter and issues instruction reads on the single-port synchronous RAM (`single_port_sync_ram_large`).
- Buffers fetched words with their PC and hands them to the decode/execute stage over a valid/ready handshake.
- The execute stage drives redirects (jump, taken skip, halt loop) and arbitrates the RAM port via a grant.

## Interface

- `ADDR_WIDTH`, 28: RAM address width; `mem_addr` is `pc[ADDR_WIDTH-1:0]`.
- `DATA_WIDTH`, 32: instruction/RAM word width.
- `RESET_PC`, 'h100: PC value after reset.
- `FIFO_DEPTH`, 2: instruction buffer entries, power of two, ≥2.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_gnt`  in  1  execute stage grants the RAM port for a new fetch this cycle.
- `mem_addr`  out  ADDR_WIDTH  registered read address.
- `mem_cs`  out  1  registered chip select.
- `mem_oe`  out  1  registered output enable (read).
- `mem_we`  out  1  tied 0; fetch never writes.
- `mem_rdata`  in  DATA_WIDTH  RAM read data.
- `instr_valid`  out  1  buffer head valid.
- `instr`  out  DATA_WIDTH  buffer head instruction.
- `instr_pc`  out  32  PC of buffer head.
- `instr_ready`  in  1  consumer accepts head this cycle.
- `redirect_valid`  in  1  replace fetch PC and flush.
- `redirect_pc`  in  32  new fetch PC.
- `halt`  in  1  level; suppresses new fetch issues.

## Operation

- **Internal state:**
  - `fetch_pc`, 32 bits, reset `RESET_PC`.
  - `outstanding`, 1 bit: a read is in flight.
  - `tag_pc`: PC of the in-flight read.
  - `drop`, 1 bit: discard the in-flight read.
  - FIFO of {instr, pc}.
- **Issue condition, evaluated each edge:** `!rst && mem_gnt && !halt && !redirect_valid && (count + outstanding - pop) < FIFO_DEPTH`.
  - When met: `mem_addr <= fetch_pc[ADDR_WIDTH-1:0]`, `mem_cs <= 1`, `mem_oe <= 1`, `tag_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 2` (mod 2^32), `outstanding <= 1`.
  - When not met: `mem_cs <= 0`, `mem_oe <= 0`; `mem_addr` holds.
- **Capture:** at the edge after an issue, `mem_rdata` is pushed into the FIFO with `tag_pc`, unless `drop` is set.
  - Capture and a new issue may occur on the same edge, so throughput is 1 instruction/cycle.
- **Pop:** occurs when `instr_valid && instr_ready`. Push and pop on the same edge are legal at any count.
- **Redirect, highest priority:**
  - Flush the FIFO (count 0) and set `fetch_pc <= redirect_pc`. No issue occurs that edge.
  - If a read is outstanding, set `drop` so its data is discarded at the next edge.
  - A simultaneous pop is ignored.
- **Halt:** blocks issues only. An outstanding read still completes, and buffered entries still drain. Redirect while halted updates the PC; fetch resumes when `halt` falls.
- **Grant low:** blocks issues only. An in-flight capture still completes.
- **`instr`/`instr_pc`:** come from FIFO head storage. `instr_valid = (count != 0)`.

## Timing

- **Reset values, asserted asynchronously and immediately:**
  - `mem_cs`, `mem_oe`, `mem_we`, `mem_addr`, `instr_valid`, `instr`, `instr_pc` = 0.
  - `fetch_pc = RESET_PC`; outstanding, drop and FIFO cleared.
- **Start-up:** first issue occurs at the first rising edge with `rst` low and the issue condition true.
- **Latency:** issue edge E, capture edge E+1, so `instr_valid` rises after E+1.
- **Reset mid-operation:** the in-flight read is abandoned, and the first fetch after release is `RESET_PC`.
- **Full buffer:** `mem_cs` drops at the edge where no credit remains. No overflow is possible by construction.
- **PC wrap:** 'hFFFFFFFE + 2 = 'h0. `mem_addr` is the truncated low bits.

## Structure

- **`cpu_pkg` holds:**
  - `PC_STEP` = 2.
  - `RESET_PC_DEFAULT` = 'h100.
  - Opcode field positions (`IR[31]` addressing mode, `IR[30:27]` opcode).
  - Typedef `fetch_entry_t` {instr, pc}.
- **Sub-module `fetch_fifo`:** synchronous FIFO with flush, push/pop, count; parameterized by depth and entry type.
- Top level holds PC, issue/credit logic and drop tracking.

## Test plan

- **Back-to-back fetch.**
  - Stimulus: RAM[0x100]=0x1000011E, RAM[0x102]=0x00000120, RAM[0x104]=0x1800011C; `gnt=1`, `ready=1`; release reset.
  - Expected: `mem_addr` 0x100, 0x102, 0x104 on consecutive edges. Outputs (0x1000011E, pc 0x100), (0x00000120, 0x102), (0x1800011C, 0x104), one per cycle.
- **Backpressure.**
  - Stimulus: `ready=0`.
  - Expected: exactly 2 issues (0x100, 0x102), then `mem_cs=0`. Raising `ready` drains 0x100 then 0x102 in order, and the next issue is 0x104.
- **Redirect with an in-flight read.**
  - Stimulus: `redirect_valid` with `redirect_pc`=0x11A on the edge after the 0x102 issue.
  - Expected: the 0x102 data is never output. The next `instr` is 0x7800000A, pc 0x11A.
- **Grant and halt gaps.**
  - Stimulus: `gnt=0` for 3 cycles, then `halt=1`.
  - Expected: no `mem_cs` during either; buffered entries still delivered. Fetch resumes at the exact next PC.
- **Asynchronous reset mid-fetch.**
  - Stimulus: assert `rst` between edges while `mem_cs=1`.
  - Expected: `mem_cs` and `instr_valid` go 0 without a clock edge. After release, the first `mem_addr` is 0x100.
- **PC wrap.**
  - Stimulus: redirect to 'hFFFFFFFE.
  - Expected: `instr_pc` sequence 'hFFFFFFFE, 'h0. `mem_addr` = 'hFFFFFFE, then 'h0.
